// File: rtl/run_length_detector.sv
// Run-length detector: 3-state FSM plus a saturating run counter with Moore zero/one run flags.
// Optional hit-event counter is built when RUN_LENGTH_DETECTOR_HIT_COUNT_EN is defined.
module run_length_detector #(
    parameter int ZERO_RUN = 4,
    parameter int ONE_RUN  = 4,
    parameter int HIT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       det_mask,
    output logic             z,
    output logic             z_zero,
    output logic             z_one,
    output logic [7:0]       run_len,
    output logic [1:0]       state,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZRUN = 2'd1,
        ORUN = 2'd2
    } state_t;

    localparam logic [7:0] ZERO_TH = 8'(ZERO_RUN);
    localparam logic [7:0] ONE_TH  = 8'(ONE_RUN);

    state_t     state_reg, state_next;
    logic [7:0] run_len_reg, run_len_next;
    logic [7:0] run_len_inc;
    logic [1:0] run_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            run_len_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            run_len_reg <= run_len_next;
        end
    end

    assign run_len_inc = (run_len_reg == 8'hFF) ? run_len_reg : run_len_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        run_len_next = run_len_reg;
        if (en) begin
            unique case (state_reg)
                ZRUN: begin
                    if (!w) begin
                        run_len_next = run_len_inc;
                    end else begin
                        state_next   = ORUN;
                        run_len_next = 8'd1;
                    end
                end
                ORUN: begin
                    if (w) begin
                        run_len_next = run_len_inc;
                    end else begin
                        state_next   = ZRUN;
                        run_len_next = 8'd1;
                    end
                end
                default: begin
                    state_next   = w ? ORUN : ZRUN;
                    run_len_next = 8'd1;
                end
            endcase
        end
    end

    // Index 0 decodes the zero-run flag, index 1 the one-run flag.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag
            localparam state_t     RUN_ST = (gi == 0) ? ZRUN : ORUN;
            localparam logic [7:0] RUN_TH = (gi == 0) ? ZERO_TH : ONE_TH;
            assign run_flag[gi] = (state_reg == RUN_ST) && (run_len_reg >= RUN_TH) && det_mask[gi];
        end
    endgenerate

    assign z_zero  = run_flag[0];
    assign z_one   = run_flag[1];
    assign z       = z_zero | z_one;
    assign run_len = run_len_reg;
    assign state   = state_reg;

`ifdef RUN_LENGTH_DETECTOR_HIT_COUNT_EN
    logic             z_prev_reg;
    logic [HIT_W-1:0] hit_cnt_reg;

    // An event is a 0->1 transition of z as seen across consecutive clock cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_prev_reg  <= 1'b0;
            hit_cnt_reg <= '0;
        end else begin
            z_prev_reg <= z;
            if (z && !z_prev_reg && (hit_cnt_reg != {HIT_W{1'b1}})) begin
                hit_cnt_reg <= hit_cnt_reg + HIT_W'(1);
            end
        end
    end

    assign hit_cnt = hit_cnt_reg;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_run_length_detector;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ZRUN = 2'd1;
    localparam logic [1:0] ST_ORUN = 2'd2;

`ifdef RUN_LENGTH_DETECTOR_HIT_COUNT_EN
    localparam bit HIT_ON = 1'b1;
`else
    localparam bit HIT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic [1:0] det_mask = 2'b11;

    logic       z, z_zero, z_one;
    logic [7:0] run_len;
    logic [1:0] state;
    logic [7:0] hit_cnt;

    logic       z2, z2_zero, z2_one;
    logic [7:0] run_len2;
    logic [1:0] state2;
    logic [7:0] hit_cnt2;

    run_length_detector #(.ZERO_RUN(4), .ONE_RUN(4), .HIT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .w(w), .det_mask(det_mask),
        .z(z), .z_zero(z_zero), .z_one(z_one), .run_len(run_len),
        .state(state), .hit_cnt(hit_cnt)
    );

    run_length_detector #(.ZERO_RUN(2), .ONE_RUN(6), .HIT_W(8)) dut2 (
        .clk(clk), .reset(reset), .en(en), .w(w), .det_mask(det_mask),
        .z(z2), .z_zero(z2_zero), .z_one(z2_one), .run_len(run_len2),
        .state(state2), .hit_cnt(hit_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] len;
        logic       zz;
        logic       zo;
        logic [7:0] hit;
        logic       chk2;
        logic       zz2;
        logic       zo2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    // z seen during the current cycle / at the previous edge, and expected event count.
    logic cur_z  = 1'b0;
    logic last_z = 1'b0;
    int   exp_hit = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", name, step_no, act, expv);
        end
    endtask

    task automatic step2(input logic e, input logic b, input logic r,
                         input logic [1:0] st, input logic [7:0] len,
                         input logic zz, input logic zo,
                         input logic c2, input logic zz2, input logic zo2);
        exp_t x;
        @(negedge clk);
        en = e;
        w = b;
        reset = r;
        if (r) begin
            exp_hit = 0;
            last_z  = 1'b0;
        end else begin
            if (cur_z && !last_z && exp_hit < 255) exp_hit++;
            last_z = cur_z;
        end
        cur_z  = zz | zo;
        x.st   = st;
        x.len  = len;
        x.zz   = zz;
        x.zo   = zo;
        x.hit  = HIT_ON ? 8'(exp_hit) : 8'd0;
        x.chk2 = c2;
        x.zz2  = zz2;
        x.zo2  = zo2;
        q.push_back(x);
    endtask

    task automatic step(input logic e, input logic b, input logic r,
                        input logic [1:0] st, input logic [7:0] len,
                        input logic zz, input logic zo);
        step2(e, b, r, st, len, zz, zo, 1'b0, 1'b0, 1'b0);
    endtask

    // Change the mask mid-cycle (after the pending edge) and check flags with no edge.
    task automatic mask_now(input logic [1:0] m, input logic zz, input logic zo);
        @(posedge clk);
        #2;
        det_mask = m;
        #1;
        chk("mask_z_zero", int'(z_zero), int'(zz));
        chk("mask_z_one", int'(z_one), int'(zo));
        chk("mask_z", int'(z), int'(zz | zo));
        cur_z = zz | zo;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                step_no++;
                chk("state", int'(state), int'(x.st));
                chk("run_len", int'(run_len), int'(x.len));
                chk("z_zero", int'(z_zero), int'(x.zz));
                chk("z_one", int'(z_one), int'(x.zo));
                chk("z", int'(z), int'(x.zz | x.zo));
                chk("hit_cnt", int'(hit_cnt), int'(x.hit));
                if (x.chk2) begin
                    chk("dut2_z_zero", int'(z2_zero), int'(x.zz2));
                    chk("dut2_z_one", int'(z2_one), int'(x.zo2));
                    chk("dut2_z", int'(z2), int'(x.zz2 | x.zo2));
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] l;
        // Reset cycle and the cycle after.
        step2(0, 0, 1, ST_IDLE, 0, 0, 0, 1, 0, 0);
        step2(0, 0, 0, ST_IDLE, 0, 0, 0, 1, 0, 0);

        // Four zeros: flag after the 4th (dut2 threshold 2 after the 2nd).
        step2(1, 0, 0, ST_ZRUN, 1, 0, 0, 1, 0, 0);
        step2(1, 0, 0, ST_ZRUN, 2, 0, 0, 1, 1, 0);
        step2(1, 0, 0, ST_ZRUN, 3, 0, 0, 1, 1, 0);
        step2(1, 0, 0, ST_ZRUN, 4, 1, 0, 1, 1, 0);

        // Ones 1..5 then a zero.
        for (int i = 1; i <= 5; i++) step2(1, 1, 0, ST_ORUN, 8'(i), 0, (i >= 4), 1, 0, 0);
        step2(1, 0, 0, ST_ZRUN, 1, 0, 0, 1, 0, 0);

        // 0,0,1x6 against ZERO_RUN=2 / ONE_RUN=6.
        step2(0, 0, 1, ST_IDLE, 0, 0, 0, 1, 0, 0);
        step2(1, 0, 0, ST_ZRUN, 1, 0, 0, 1, 0, 0);
        step2(1, 0, 0, ST_ZRUN, 2, 0, 0, 1, 1, 0);
        for (int i = 1; i <= 6; i++) step2(1, 1, 0, ST_ORUN, 8'(i), 0, (i >= 4), 1, 0, (i >= 6));

        // en gating: run advances only on en=1.
        step(0, 0, 1, ST_IDLE, 0, 0, 0);
        step(1, 0, 0, ST_ZRUN, 1, 0, 0);
        step(0, 0, 0, ST_ZRUN, 1, 0, 0);
        step(0, 0, 0, ST_ZRUN, 1, 0, 0);
        step(1, 0, 0, ST_ZRUN, 2, 0, 0);
        step(1, 0, 0, ST_ZRUN, 3, 0, 0);
        step(0, 0, 0, ST_ZRUN, 3, 0, 0);
        step(1, 0, 0, ST_ZRUN, 4, 1, 0);

        // Masked zero detection, then re-enabled mid-run, then reset mid-run.
        step(0, 0, 1, ST_IDLE, 0, 0, 0);
        mask_now(2'b10, 0, 0);
        for (int i = 1; i <= 6; i++) step(1, 0, 0, ST_ZRUN, 8'(i), 0, 0);
        mask_now(2'b11, 1, 0);
        step(1, 0, 0, ST_ZRUN, 7, 1, 0);
        step(1, 0, 1, ST_IDLE, 0, 0, 0);
        step(0, 0, 0, ST_IDLE, 0, 0, 0);

        // Saturation of run_len at 255 with the flag held.
        step(0, 0, 1, ST_IDLE, 0, 0, 0);
        for (int i = 1; i <= 260; i++) begin
            l = (i > 255) ? 8'd255 : 8'(i);
            step(1, 1, 0, ST_ORUN, l, 0, (i >= 4));
        end
        step(1, 0, 0, ST_ZRUN, 1, 0, 0);

        // 300 alternating bursts: one event each, hit counter saturates when built.
        step(0, 0, 1, ST_IDLE, 0, 0, 0);
        for (int b = 0; b < 150; b++) begin
            for (int i = 1; i <= 4; i++) step(1, 0, 0, ST_ZRUN, 8'(i), (i == 4), 0);
            for (int i = 1; i <= 4; i++) step(1, 1, 0, ST_ORUN, 8'(i), 0, (i == 4));
        end
        step(0, 0, 0, ST_ORUN, 4, 0, 1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        chk("final_hit_cnt", int'(hit_cnt), HIT_ON ? 255 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
